// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bundle: imem req/gnt/rvalid port, decode-side handshake,
// branch redirect and halt. The sequencer is the master; memory/core side is the slave.
interface fetch_sequencer_if;
  logic        halt;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [29:0] instr_pc;
  logic        instr_ready;
  logic        jmp_enable;
  logic [29:0] jmp_addr;

  modport master (
    input  halt, imem_gnt, imem_rvalid, imem_rdata, instr_ready, jmp_enable, jmp_addr,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output halt, imem_gnt, imem_rvalid, imem_rdata, instr_ready, jmp_enable, jmp_addr,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: owns the word PC, fetches one
// instruction, holds it for the core until retire, then redirects or advances.
module fetch_sequencer #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   bus,
  output logic [2:0]          dbg_state
);

  // Handshakes: imem_req stays high with imem_addr stable until imem_gnt is
  // seen on a rising edge; imem_rvalid is honoured only while a granted fetch
  // is outstanding; instr_valid/instr/instr_pc stay stable until instr_ready
  // is seen on a rising edge while instr_valid is high.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    HOLD     = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] pc;
  logic [29:0] pc_nxt;
  logic [31:0] instr_r;
  logic [29:0] instr_pc_r;
  logic        valid_r;
  logic        capture;
  logic        retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr_r    <= 32'h0;
      instr_pc_r <= RESET_PC;
      valid_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        instr_r    <= bus.imem_rdata;
        instr_pc_r <= pc;
      end
      if (capture) begin
        valid_r <= 1'b1;
      end else if (retire) begin
        valid_r <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = bus.halt ? HALTED : REQ;
      end
      REQ: begin
        if (bus.imem_gnt) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.imem_rvalid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Redirect inputs are only meaningful on the retire edge.
        if (bus.instr_ready) begin
          retire    = 1'b1;
          pc_nxt    = bus.jmp_enable ? bus.jmp_addr : pc + 30'd1;
          state_nxt = bus.halt ? HALTED : REQ;
        end
      end
      HALTED: begin
        if (!bus.halt) begin
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory/core responder driven step by step,
// expected fetch addresses and instructions tracked in scoreboard queues.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  logic [2:0] w_dbg_state;
  int         cyc;
  int         checks;
  int         failures;

  logic [29:0] addr_q[$];
  logic [61:0] instr_q[$];

  fetch_sequencer_if m_if ();
  fetch_sequencer_if w_if ();

  fetch_sequencer #(.RESET_PC(30'h0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (m_if),
    .dbg_state (dbg_state)
  );

  fetch_sequencer #(.RESET_PC(30'h3FFFFFFF)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .bus       (w_if),
    .dbg_state (w_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: serve one complete fetch on the main DUT
  task automatic serve(input int gnt_wait, input int rsp_wait, input logic jmp,
                       input logic [29:0] jaddr, input logic hlt, output int req_cyc);
    logic [29:0] exp_a;
    logic [61:0] exp_i;
    int n;
    n = 0;
    while (m_if.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {63'd0, m_if.imem_req}, 64'd1);
    req_cyc = cyc;
    if (addr_q.size() == 0) begin
      check("addr_q_nonempty", 64'd0, 64'd1);
      exp_a = 30'h0;
    end else begin
      exp_a = addr_q.pop_front();
    end
    check("req_addr", {34'd0, m_if.imem_addr}, {34'd0, exp_a});
    for (int i = 0; i < gnt_wait; i++) begin
      m_if.imem_rvalid = 1'b1;
      m_if.imem_rdata  = $urandom;
      m_if.instr_ready = 1'b1;
      @(negedge clk);
      check("req_hold", {63'd0, m_if.imem_req}, 64'd1);
      check("addr_hold", {34'd0, m_if.imem_addr}, {34'd0, exp_a});
      check("stray_rvalid", {63'd0, m_if.instr_valid}, 64'd0);
    end
    m_if.imem_rvalid = 1'b0;
    m_if.instr_ready = 1'b0;
    m_if.imem_gnt    = 1'b1;
    instr_q.push_back({exp_a, mem_word(exp_a)});
    @(negedge clk);
    m_if.imem_gnt = (rsp_wait > 0);
    check("req_drop", {63'd0, m_if.imem_req}, 64'd0);
    for (int i = 0; i < rsp_wait; i++) begin
      @(negedge clk);
      check("wait_valid", {63'd0, m_if.instr_valid}, 64'd0);
      check("wait_req", {63'd0, m_if.imem_req}, 64'd0);
    end
    m_if.imem_gnt    = 1'b0;
    m_if.imem_rvalid = 1'b1;
    m_if.imem_rdata  = mem_word(exp_a);
    @(negedge clk);
    m_if.imem_rvalid = 1'b0;
    m_if.imem_rdata  = $urandom;
    check("valid_rise", {63'd0, m_if.instr_valid}, 64'd1);
    exp_i = instr_q.pop_front();
    check("instr", {32'd0, m_if.instr}, {32'd0, exp_i[31:0]});
    check("instr_pc", {34'd0, m_if.instr_pc}, {34'd0, exp_i[61:32]});
    m_if.instr_ready = 1'b1;
    m_if.jmp_enable  = jmp;
    m_if.jmp_addr    = jmp ? jaddr : 30'($urandom);
    m_if.halt        = hlt;
    @(negedge clk);
    m_if.instr_ready = 1'b0;
    m_if.jmp_enable  = 1'b1;
    m_if.jmp_addr    = 30'($urandom);
    check("valid_fall", {63'd0, m_if.instr_valid}, 64'd0);
  endtask

  int c0, c1, c2, cx;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    m_if.halt = 1'b0;        w_if.halt = 1'b0;
    m_if.imem_gnt = 1'b0;    w_if.imem_gnt = 1'b0;
    m_if.imem_rvalid = 1'b0; w_if.imem_rvalid = 1'b0;
    m_if.imem_rdata = '0;    w_if.imem_rdata = '0;
    m_if.instr_ready = 1'b0; w_if.instr_ready = 1'b0;
    m_if.jmp_enable = 1'b1;  w_if.jmp_enable = 1'b0;
    m_if.jmp_addr = 30'h2AAA_AAAA; w_if.jmp_addr = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {63'd0, m_if.imem_req}, 64'd0);
    check("rst_valid", {63'd0, m_if.instr_valid}, 64'd0);
    check("rst_instr", {32'd0, m_if.instr}, 64'd0);
    check("rst_instr_pc", {34'd0, m_if.instr_pc}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    check("rst_wrap_pc", {34'd0, w_if.instr_pc}, 64'h3FFFFFFF);
    rst = 1'b0;
    @(negedge clk);
    check("idle_to_req", {61'd0, dbg_state}, 64'd1);

    // sequential fetch with 3-cycle cadence
    addr_q.push_back(30'd0);
    addr_q.push_back(30'd1);
    addr_q.push_back(30'd2);
    serve(0, 0, 1'b0, 30'h0, 1'b0, c0);
    serve(0, 0, 1'b0, 30'h0, 1'b0, c1);
    check("cadence_1", 64'(c1 - c0), 64'd3);
    serve(0, 0, 1'b0, 30'h0, 1'b0, c2);
    check("cadence_2", 64'(c2 - c1), 64'd3);

    // redirect on retire; redirect noise outside HOLD ignored
    addr_q.push_back(30'd3);
    serve(0, 0, 1'b1, 30'h100, 1'b0, cx);
    addr_q.push_back(30'h100);
    serve(0, 2, 1'b0, 30'h0, 1'b0, cx);

    // grant withheld with stray rvalid and early ready
    addr_q.push_back(30'h101);
    serve(5, 0, 1'b0, 30'h0, 1'b0, cx);

    // halt on retire, resume at pc+1
    addr_q.push_back(30'h102);
    serve(0, 0, 1'b0, 30'h0, 1'b1, cx);
    for (int i = 0; i < 3; i++) begin
      check("halted_state", {61'd0, dbg_state}, 64'd4);
      check("halted_req", {63'd0, m_if.imem_req}, 64'd0);
      check("halted_valid", {63'd0, m_if.instr_valid}, 64'd0);
      @(negedge clk);
    end
    m_if.halt = 1'b0;
    @(negedge clk);
    check("resume_req", {63'd0, m_if.imem_req}, 64'd1);
    addr_q.push_back(30'h103);
    serve(0, 0, 1'b0, 30'h0, 1'b0, cx);

    // reset during WAIT_RSP, stale rvalid after release
    @(negedge clk);
    check("pre_rst_addr", {34'd0, m_if.imem_addr}, 64'h104);
    m_if.imem_gnt = 1'b1;
    @(negedge clk);
    m_if.imem_gnt = 1'b0;
    check("pre_rst_state", {61'd0, dbg_state}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    instr_q.delete();
    @(negedge clk);
    m_if.imem_rvalid = 1'b1;
    m_if.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    m_if.imem_rvalid = 1'b0;
    check("stale_valid", {63'd0, m_if.instr_valid}, 64'd0);
    check("stale_instr", {32'd0, m_if.instr}, 64'd0);
    check("post_rst_req", {63'd0, m_if.imem_req}, 64'd1);
    addr_q.push_back(30'd0);
    serve(0, 0, 1'b0, 30'h0, 1'b0, cx);

    // PC wrap on the second instance
    check("wrap_req", {63'd0, w_if.imem_req}, 64'd1);
    check("wrap_addr0", {34'd0, w_if.imem_addr}, 64'h3FFFFFFF);
    w_if.imem_gnt = 1'b1;
    @(negedge clk);
    w_if.imem_gnt    = 1'b0;
    w_if.imem_rvalid = 1'b1;
    w_if.imem_rdata  = mem_word(30'h3FFFFFFF);
    @(negedge clk);
    w_if.imem_rvalid = 1'b0;
    check("wrap_valid", {63'd0, w_if.instr_valid}, 64'd1);
    check("wrap_instr", {32'd0, w_if.instr}, {32'd0, mem_word(30'h3FFFFFFF)});
    check("wrap_instr_pc", {34'd0, w_if.instr_pc}, 64'h3FFFFFFF);
    w_if.instr_ready = 1'b1;
    @(negedge clk);
    w_if.instr_ready = 1'b0;
    check("wrap_next_req", {63'd0, w_if.imem_req}, 64'd1);
    check("wrap_next_addr", {34'd0, w_if.imem_addr}, 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
